// File: rtl/serial_seq_pkg.sv
// Shared types and helpers for the serial shift sequencer.
package serial_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  // Width of the shift counter: must hold DATA_W+1 (parity shift) with room to spare.
  function automatic int count_width(input int data_w);
    return $clog2(data_w + 2);
  endfunction

endpackage

// File: rtl/button_edge_sync.sv
// Two-flop synchroniser plus falling-edge detector for an active-low push button.
// press_o is high for exactly one cycle per press.
module button_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic btn_n_i,
  output logic press_o
);

  logic r_q;
  logic rr_q;

  // Shift the raw button level through the sync pair; cleared on reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q  <= 1'b0;
      rr_q <= 1'b0;
    end else begin
      r_q  <= btn_n_i;
      rr_q <= r_q;
    end
  end

  // Falling edge: previous sample high, current sample low.
  assign press_o = rr_q & ~r_q;

endmodule

// File: rtl/serial_shift_sequencer.sv
// Automatic load/shift sequencer for the serial shift-register datapath.
// One start press loads a byte, then issues N evenly spaced shift strobes.
// Optional feature: define SEQ_PARITY_EN to append one extra shift carrying
// the even parity of the captured word (N = DATA_W+1 instead of DATA_W).
module serial_shift_sequencer
  import serial_seq_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int TICK_DIV = 25_000_000,
  localparam int CW       = count_width(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] switches,
  input  logic              fill_value,
  input  logic              start_button,
  input  logic              stop_button,
  output logic              load_pulse,
  output logic [DATA_W-1:0] load_data,
  output logic              shift_pulse,
  output logic              shift_in,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     shift_count
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
`ifdef SEQ_PARITY_EN
  localparam int N = DATA_W + 1;
`else
  localparam int N = DATA_W;
`endif
  localparam logic [CW-1:0] N_CW = CW'(N);

  seq_state_e        state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              start_ev;
  logic              stop_ev;

  button_edge_sync u_start_sync (
    .clk     (clk),
    .reset   (reset),
    .btn_n_i (start_button),
    .press_o (start_ev)
  );

  button_edge_sync u_stop_sync (
    .clk     (clk),
    .reset   (reset),
    .btn_n_i (stop_button),
    .press_o (stop_ev)
  );

  // State, tick counter, shift counter and captured word; all cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  // Next-state and strobe decode; a stop event overrides every other transition.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    count_d     = count_q;
    data_d      = data_q;
    load_pulse  = 1'b0;
    shift_pulse = 1'b0;
    shift_in    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ev) begin
          data_d  = switches;
          count_d = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_pulse = 1'b1;
        busy       = 1'b1;
        tick_d     = '0;
        state_d    = stop_ev ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (stop_ev) begin
          state_d = ST_IDLE;
        end else if (tick_q == TICK_LAST) begin
          state_d = ST_SHIFT;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        busy        = 1'b1;
        shift_pulse = 1'b1;
        shift_in    = fill_value;
`ifdef SEQ_PARITY_EN
        // The last shift of the sequence carries the parity bit, not the fill bit.
        if (count_q == CW'(DATA_W)) begin
          shift_in = ^data_q;
        end
`endif
        count_d = count_q + 1'b1;
        if (stop_ev) begin
          state_d = ST_IDLE;
        end else if (count_d == N_CW) begin
          state_d = ST_DONE;
        end else begin
          tick_d  = '0;
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign load_data   = data_q;
  assign shift_count = count_q;

endmodule
